qmr_fault_manager: RTL and testbench

Sequencing and fault-management controller for the quintuple-modular-redundant ALU bank and its majority voter. Accepts one operation at a time from the execute stage, fires the five ALUs, samples the voter, retries when no majority exists, and returns a single voted result. Tracks per-ALU dissent history, quarantines persistently faulty ALUs, and exposes correction statistics for the telemetry path.

---
 rtl/qmr_fault_manager_if.sv | 27 ++
 rtl/qmr_fault_manager.sv | 118 +++++++++++
 tb/tb_qmr_fault_manager.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/qmr_fault_manager_if.sv
// Handshake and ALU-bank/voter bundle between the execute stage, the QMR
// controller and the redundant ALU bank.
interface qmr_fault_manager_if #(
  parameter int WIDTH = 64
);
  logic             op_valid;
  logic             op_ready;
  logic             alu_start;
  logic [4:0]       alu_disable;
  logic [14:0]      vote_count;
  logic [2:0]       majority_status;
  logic [WIDTH-1:0] voted_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_error;

  modport master (
    input  op_valid, vote_count, majority_status, voted_result, res_ready,
    output op_ready, alu_start, alu_disable, res_valid, res_data, res_error
  );

  modport slave (
    output op_valid, vote_count, majority_status, voted_result, res_ready,
    input  op_ready, alu_start, alu_disable, res_valid, res_data, res_error
  );
endinterface

// File: rtl/qmr_fault_manager.sv
// Sequencer for the five-way redundant ALU bank: issue, vote, retry on no
// majority, return one result, and quarantine ALUs that keep dissenting.
module qmr_fault_manager #(
  parameter int WIDTH        = 64,
  parameter int FAULT_THRESH = 4,
  parameter int MAX_RETRY    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qmr_fault_manager_if.master  bus,
  input  logic                 i_fault_clear,
  output logic [15:0]          o_stat_corrected,
  output logic [15:0]          o_stat_uncorrectable
);
  localparam logic [3:0] THRESH    = 4'(FAULT_THRESH);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_RESP} state_t;

  state_t           r_state;
  logic [2:0]       r_retry;
  logic [4:0][3:0]  r_dissent;
  logic [4:0]       r_disable;
  logic             r_op_ready;
  logic             r_alu_start;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_error;
  logic [15:0]      r_stat_corr;
  logic [15:0]      r_stat_unc;

  logic [4:0]       w_dissent;
  logic [4:0][3:0]  w_cnt_inc;

  // An ALU dissents when it is still enabled and fewer than three voters agree with it.
  for (genvar gi = 0; gi < 5; gi++) begin : g_alu
    assign w_dissent[gi] = ~r_disable[gi] && (bus.vote_count[3*gi +: 3] < 3'd3);
    assign w_cnt_inc[gi] = (r_dissent[gi] == 4'hF) ? 4'hF : r_dissent[gi] + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_retry     <= '0;
      r_dissent   <= '0;
      r_disable   <= '0;
      r_op_ready  <= 1'b1;
      r_alu_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_error <= 1'b0;
      r_stat_corr <= '0;
      r_stat_unc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            r_state     <= S_ISSUE;
            r_op_ready  <= 1'b0;
            r_alu_start <= 1'b1;
            r_retry     <= '0;
          end
        end
        S_ISSUE: begin
          r_alu_start <= 1'b0;
          r_state     <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.majority_status != 3'd0) begin
            r_res_data  <= bus.voted_result;
            r_res_error <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
            for (int i = 0; i < 5; i++) begin
              if (w_dissent[i]) begin
                r_dissent[i] <= w_cnt_inc[i];
                if (w_cnt_inc[i] >= THRESH) r_disable[i] <= 1'b1;
              end
            end
            if ((|w_dissent) && (r_stat_corr != 16'hFFFF)) r_stat_corr <= r_stat_corr + 16'd1;
          end else if (r_retry < RETRY_LIM) begin
            r_retry     <= r_retry + 3'd1;
            r_alu_start <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_res_data  <= bus.voted_result;
            r_res_error <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
            if (r_stat_unc != 16'hFFFF) r_stat_unc <= r_stat_unc + 16'd1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_op_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Clear overrides any dissent/quarantine update made in the same cycle.
      if (i_fault_clear) begin
        r_dissent <= '0;
        r_disable <= '0;
      end
    end
  end

  assign bus.op_ready          = r_op_ready;
  assign bus.alu_start         = r_alu_start;
  assign bus.alu_disable       = r_disable;
  assign bus.res_valid         = r_res_valid;
  assign bus.res_data          = r_res_data;
  assign bus.res_error         = r_res_error;
  assign o_stat_corrected      = r_stat_corr;
  assign o_stat_uncorrectable  = r_stat_unc;
endmodule

// File: tb/tb_qmr_fault_manager.sv
// Directed plus randomized bench for qmr_fault_manager with a rule-level
// model of voting outcome, dissent history, quarantine and statistics.
module tb_qmr_fault_manager;
  localparam int WIDTH        = 64;
  localparam int FAULT_THRESH = 4;
  localparam int MAX_RETRY    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fault_clear = 1'b0;
  logic [15:0] o_stat_corrected;
  logic [15:0] o_stat_uncorrectable;

  qmr_fault_manager_if #(.WIDTH(WIDTH)) bus ();

  qmr_fault_manager #(
    .WIDTH(WIDTH), .FAULT_THRESH(FAULT_THRESH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_fault_clear(i_fault_clear),
    .o_stat_corrected(o_stat_corrected), .o_stat_uncorrectable(o_stat_uncorrectable)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model state
  int m_cnt[5];
  bit m_dis[5];
  int m_corr, m_unc;

  // Planned voter outcome per attempt of the current op
  logic [14:0] p_vc[8];
  logic [2:0]  p_st[8];
  logic [63:0] p_res[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] vc5(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [4:0] m_mask();
    logic [4:0] m = '0;
    for (int i = 0; i < 5; i++) m[i] = m_dis[i];
    return m;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; m_dis[i] = 0; end
  endtask

  task automatic plan_all(input int n, input logic [14:0] vc, input logic [2:0] st, input logic [63:0] r);
    for (int i = 0; i < n; i++) begin p_vc[i] = vc; p_st[i] = st; p_res[i] = r; end
  endtask

  // One full transaction: accept, serve the ALU bank, check, hold in RESP, handshake.
  task automatic run_op(input string name, input int hold, input bit clr);
    int f, lat, starts, att;
    bit clr_next, any;
    logic [63:0] exp_data;
    bit exp_err;
    logic [63:0] held;
    f = MAX_RETRY;
    for (int k = MAX_RETRY; k >= 0; k--) if (p_st[k] != 3'd0) f = k;
    exp_data = p_res[f];
    exp_err  = (p_st[f] == 3'd0);

    chk({name, "_op_ready_idle"}, bus.op_ready, 1);
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    lat = 1; starts = 0; att = 0; clr_next = 0;
    while (!bus.res_valid && lat < 40) begin
      if (bus.alu_start) begin
        starts++;
        if (att < 8) begin
          bus.vote_count = p_vc[att]; bus.majority_status = p_st[att]; bus.voted_result = p_res[att];
          if (clr && att == f) clr_next = 1;
        end
        att++;
      end
      @(posedge clk); #1;
      i_fault_clear = clr_next;
      clr_next = 0;
      lat++;
    end
    i_fault_clear = 1'b0;
    chk({name, "_latency"}, 64'(lat), 64'(3 + 2 * f));
    chk({name, "_alu_starts"}, 64'(starts), 64'(f + 1));
    chk({name, "_res_data"}, bus.res_data, exp_data);
    chk({name, "_res_error"}, bus.res_error, exp_err);

    if (exp_err) m_unc++;
    else begin
      any = 0;
      for (int i = 0; i < 5; i++) begin
        if (!m_dis[i] && p_vc[f][3*i +: 3] < 3) begin
          any = 1;
          if (m_cnt[i] < 15) m_cnt[i]++;
          if (m_cnt[i] >= FAULT_THRESH) m_dis[i] = 1;
        end
      end
      if (any) m_corr++;
    end
    if (m_corr > 16'hFFFF) m_corr = 16'hFFFF;
    if (clr) m_clear();

    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      bus.op_valid = 1'b1;
      bus.res_ready = 1'b0;
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, bus.res_valid, 1);
      chk({name, "_hold_data"}, bus.res_data, held);
      chk({name, "_hold_op_ready"}, bus.op_ready, 0);
      chk({name, "_hold_no_start"}, bus.alu_start, 0);
    end
    bus.op_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({name, "_res_valid_drop"}, bus.res_valid, 0);
    chk({name, "_op_ready_back"}, bus.op_ready, 1);
    chk({name, "_alu_disable"}, bus.alu_disable, m_mask());
    chk({name, "_stat_corr"}, o_stat_corrected, 64'(m_corr));
    chk({name, "_stat_unc"}, o_stat_uncorrectable, 64'(m_unc));
    $display("op %s: attempts=%0d data=%h err=%0d disable=%b corr=%0d unc=%0d",
             name, starts, exp_data, exp_err, m_mask(), m_corr, m_unc);
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    bus.vote_count = '0; bus.majority_status = '0; bus.voted_result = '0;
    m_clear(); m_corr = 0; m_unc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_error", bus.res_error, 0);
    chk("rst_disable", bus.alu_disable, 0);
    chk("rst_stats", {o_stat_corrected, o_stat_uncorrectable}, 0);

    plan_all(3, vc5(5, 5, 5, 5, 5), 3'd1, 64'h1234);
    run_op("agree", 0, 0);

    plan_all(3, vc5(4, 4, 1, 4, 4), 3'd1, 64'hABCD);
    for (int n = 0; n < 5; n++) run_op($sformatf("alu3_dissent%0d", n), 0, 0);
    chk("alu3_quarantine", bus.alu_disable, 5'b00100);

    plan_all(3, vc5(5, 5, 0, 5, 5), 3'd0, 64'h55);
    p_st[1] = 3'd2; p_res[1] = 64'h9999;
    run_op("retry_once", 0, 0);

    plan_all(3, vc5(2, 2, 1, 0, 0), 3'd0, 64'hDEAD);
    p_res[2] = 64'hBEEF;
    run_op("uncorrectable", 0, 0);

    plan_all(3, vc5(5, 5, 0, 5, 5), 3'd4, 64'hCAFE);
    run_op("hold10", 10, 0);

    i_fault_clear = 1'b1;
    @(posedge clk); #1;
    i_fault_clear = 1'b0;
    m_clear();
    chk("idle_clear", bus.alu_disable, 0);

    plan_all(3, vc5(0, 5, 5, 5, 5), 3'd2, 64'h77);
    for (int n = 0; n < 3; n++) run_op($sformatf("alu1_dissent%0d", n), 0, 0);
    run_op("clear_vs_quarantine", 0, 1);
    for (int n = 0; n < 3; n++) run_op($sformatf("after_clear%0d", n), 0, 0);

    for (int n = 0; n < 30; n++) begin
      for (int a = 0; a < 3; a++) begin
        p_vc[a]  = 15'($urandom_range(0, 32767));
        p_st[a]  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
        p_res[a] = {$urandom, $urandom};
      end
      run_op($sformatf("rand%0d", n), $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
    end

    // Abort in the middle of an op: everything returns to reset values.
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.majority_status = 3'd1; bus.vote_count = vc5(0, 0, 0, 0, 0); bus.voted_result = 64'h4242;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_op_ready", bus.op_ready, 1);
    chk("abort_alu_start", bus.alu_start, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_res_data", bus.res_data, 0);
    chk("abort_res_error", bus.res_error, 0);
    chk("abort_disable", bus.alu_disable, 0);
    chk("abort_stats", {o_stat_corrected, o_stat_uncorrectable}, 0);
    @(posedge clk); #1;
    chk("abort_no_result", bus.res_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
